// File: rtl/ray_pixel_collector_if.sv
// rtl/ray_pixel_collector_if.sv - ray in / pixel out bundle for the ray pixel collector
interface ray_pixel_collector_if;
   logic        start;
   logic [12:0] image_width;
   logic [12:0] image_height;
   logic        ray_valid;
   logic        ray_ready;
   logic [31:0] ray_dir_x;
   logic [31:0] ray_dir_y;
   logic [31:0] ray_dir_z;
   logic        pix_valid;
   logic        pix_ready;
   logic [12:0] pix_x;
   logic [12:0] pix_y;
   logic [25:0] pix_addr;
   logic [23:0] pix_colour;
   logic        frame_done;
   logic        busy;

   modport master (
      output start, image_width, image_height, ray_valid, ray_dir_x, ray_dir_y, ray_dir_z, pix_ready,
      input  ray_ready, pix_valid, pix_x, pix_y, pix_addr, pix_colour, frame_done, busy
   );

   modport slave (
      input  start, image_width, image_height, ray_valid, ray_dir_x, ray_dir_y, ray_dir_z, pix_ready,
      output ray_ready, pix_valid, pix_x, pix_y, pix_addr, pix_colour, frame_done, busy
   );
endinterface

// File: rtl/ray_pixel_collector.sv
// rtl/ray_pixel_collector.sv - classifies rays into colours, buffers them and streams raster-order pixels
module ray_pixel_collector #(
   parameter int          FIFO_DEPTH    = 4,
   parameter logic [23:0] SKY_COLOUR    = 24'h87CEEB,
   parameter logic [23:0] GROUND_COLOUR = 24'h228B22
) (
   input logic                  clk,
   input logic                  reset_n,
   ray_pixel_collector_if.slave bus
);
   localparam int          AW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e        state_q, state_d;
   logic [12:0]   width_q, width_d;
   logic [25:0]   total_q, total_d;
   logic [25:0]   accepted_q, accepted_d;
   logic [12:0]   pix_x_q, pix_x_d;
   logic [12:0]   pix_y_q, pix_y_d;
   logic [25:0]   pix_addr_q, pix_addr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [23:0]   mem_q [FIFO_DEPTH];
   logic [23:0]   ray_colour;
   logic          push, pop, fifo_empty, fifo_full;
   logic          unused_dir;

   assign fifo_empty    = (count_q == '0);
   assign fifo_full     = (count_q == FULL_COUNT);
   assign bus.ray_ready = (state_q == RUN) && !fifo_full && (accepted_q < total_q);
   assign bus.pix_valid = (state_q == RUN) && !fifo_empty;
   assign push          = bus.ray_valid && bus.ray_ready;
   assign pop           = bus.pix_valid && bus.pix_ready;

   // Only the sign of y and whether z is zero matter for the colour.
   assign unused_dir = ^{bus.ray_dir_x, bus.ray_dir_y[30:0]};

   always_comb begin
      ray_colour = SKY_COLOUR;
      if (bus.ray_dir_z == 32'd0) begin
         ray_colour = 24'h000000;
      end else if (bus.ray_dir_y[31]) begin
         ray_colour = GROUND_COLOUR;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= ray_colour;
      end
   end

   always_comb begin
      state_d    = state_q;
      width_d    = width_q;
      total_d    = total_q;
      accepted_d = accepted_q;
      pix_x_d    = pix_x_q;
      pix_y_d    = pix_y_q;
      pix_addr_d = pix_addr_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               width_d    = bus.image_width;
               total_d    = 26'(bus.image_width) * 26'(bus.image_height);
               accepted_d = '0;
               pix_x_d    = '0;
               pix_y_d    = '0;
               pix_addr_d = '0;
               wr_ptr_d   = '0;
               rd_ptr_d   = '0;
               count_d    = '0;
               state_d    = RUN;
            end
         end
         RUN: begin
            if (push) begin
               wr_ptr_d   = wr_ptr_q + AW'(1);
               accepted_d = accepted_q + 26'd1;
            end
            if (pop) begin
               rd_ptr_d   = rd_ptr_q + AW'(1);
               pix_addr_d = pix_addr_q + 26'd1;
               if (pix_x_q == width_q - 13'd1) begin
                  pix_x_d = '0;
                  pix_y_d = pix_y_q + 13'd1;
               end else begin
                  pix_x_d = pix_x_q + 13'd1;
               end
            end
            if (push && !pop) begin
               count_d = count_q + (AW+1)'(1);
            end else if (!push && pop) begin
               count_d = count_q - (AW+1)'(1);
            end
            // pix_addr_q doubles as the count of pixels already written.
            if ((total_q == '0) || (pop && (pix_addr_q == total_q - 26'd1))) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         width_q    <= '0;
         total_q    <= '0;
         accepted_q <= '0;
         pix_x_q    <= '0;
         pix_y_q    <= '0;
         pix_addr_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         width_q    <= width_d;
         total_q    <= total_d;
         accepted_q <= accepted_d;
         pix_x_q    <= pix_x_d;
         pix_y_q    <= pix_y_d;
         pix_addr_q <= pix_addr_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   assign bus.pix_x      = pix_x_q;
   assign bus.pix_y      = pix_y_q;
   assign bus.pix_addr   = pix_addr_q;
   assign bus.pix_colour = bus.pix_valid ? mem_q[rd_ptr_q] : 24'h000000;
   assign bus.frame_done = (state_q == DONE);
   assign bus.busy       = (state_q != IDLE);
endmodule
